// File: rtl/urv_defs.sv
// Shared definitions for the urv load/store unit: LDST function codes and FSM state encodings.
package urv_defs;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;

endpackage

// File: rtl/urv_lsu_align.sv
// Byte-lane alignment: byte enables, lane-replicated store data and misalignment detection.
module urv_lsu_align
    import urv_defs::*;
(
    input  logic [2:0]  fun_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [3:0]  select_o,
    output logic [31:0] data_o,
    output logic        misalign_o
);

    always_comb begin
        select_o   = 4'b1111;
        data_o     = data_i;
        misalign_o = 1'b0;
        case (fun_i)
            LDST_B, LDST_BU: begin
                select_o = 4'b0001 << addr_i;
                data_o   = {4{data_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                select_o   = addr_i[1] ? 4'b1100 : 4'b0011;
                data_o     = {2{data_i[15:0]}};
                misalign_o = addr_i[0];
            end
            // Word access; unknown codes fall back to word semantics.
            default: begin
                misalign_o = (addr_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/urv_lsu.sv
// Load/store unit between execute and the data-memory bus.
// Optional bus watchdog enabled by defining URV_LSU_TIMEOUT_EN.
module urv_lsu
    import urv_defs::*;
#(
    parameter int unsigned g_timeout_cycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        e_valid_i,
    input  logic        e_load_i,
    input  logic        e_store_i,
    input  logic [2:0]  e_fun_i,
    input  logic [31:0] e_addr_i,
    input  logic [31:0] e_data_i,
    output logic        busy_o,
    output logic        misalign_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_data_s_o,
    output logic [3:0]  dm_data_select_o,
    output logic        dm_load_o,
    output logic        dm_store_o,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    input  logic        dm_store_done_i,
    output logic [31:0] w_load_data_o,
    output logic        w_load_done_o,
    output logic        w_store_done_o,
    output logic        bus_error_o
);

    logic [1:0]  state_q, state_d;
    logic [3:0]  al_select;
    logic [31:0] al_data;
    logic        al_misalign;
    logic        req, accept, reject, done_hit, expired, finish;

    logic [31:0] addr_q, addr_d, sdata_q, sdata_d, ldata_q, ldata_d;
    logic [3:0]  select_q, select_d;
    logic        load_q, load_d, store_q, store_d;
    logic        misalign_q, misalign_d;
    logic        ldone_q, ldone_d, sdone_q, sdone_d, err_q, err_d;

    urv_lsu_align u_align (
        .fun_i      (e_fun_i),
        .addr_i     (e_addr_i[1:0]),
        .data_i     (e_data_i),
        .select_o   (al_select),
        .data_o     (al_data),
        .misalign_o (al_misalign)
    );

    assign req      = e_valid_i & (e_load_i | e_store_i);
    assign accept   = (state_q == ST_IDLE) & req & ~al_misalign;
    assign reject   = (state_q == ST_IDLE) & req & al_misalign;
    assign done_hit = ((state_q == ST_LOAD) & dm_load_done_i) |
                      ((state_q == ST_STORE) & dm_store_done_i);

`ifdef URV_LSU_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(g_timeout_cycles - 1);
    logic [15:0] tmo_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || accept) begin
            tmo_cnt_q <= '0;
        end else if (state_q != ST_IDLE) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    // A done arriving on the expiry cycle takes precedence over the abort.
    assign expired = (state_q != ST_IDLE) & ~done_hit & (tmo_cnt_q == TMO_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(g_timeout_cycles);
    assign expired        = 1'b0;
`endif

    assign finish = done_hit | expired;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = e_load_i ? ST_LOAD : ST_STORE;
            ST_LOAD,
            ST_STORE: if (finish) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        select_d   = select_q;
        ldata_d    = ldata_q;
        load_d     = (state_d == ST_LOAD);
        store_d    = (state_d == ST_STORE);
        misalign_d = reject;
        ldone_d    = (state_q == ST_LOAD) & finish;
        sdone_d    = (state_q == ST_STORE) & finish;
        err_d      = expired;
        if (accept) begin
            addr_d   = {e_addr_i[31:2], 2'b00};
            sdata_d  = al_data;
            select_d = al_select;
        end
        if (state_q == ST_LOAD) begin
            if (dm_load_done_i) ldata_d = dm_data_l_i;
            else if (expired)   ldata_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            sdata_q    <= '0;
            select_q   <= '0;
            ldata_q    <= '0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            misalign_q <= 1'b0;
            ldone_q    <= 1'b0;
            sdone_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            select_q   <= select_d;
            ldata_q    <= ldata_d;
            load_q     <= load_d;
            store_q    <= store_d;
            misalign_q <= misalign_d;
            ldone_q    <= ldone_d;
            sdone_q    <= sdone_d;
            err_q      <= err_d;
        end
    end

    assign busy_o           = (state_q != ST_IDLE);
    assign misalign_o       = misalign_q;
    assign dm_addr_o        = addr_q;
    assign dm_data_s_o      = sdata_q;
    assign dm_data_select_o = select_q;
    assign dm_load_o        = load_q;
    assign dm_store_o       = store_q;
    assign w_load_data_o    = ldata_q;
    assign w_load_done_o    = ldone_q;
    assign w_store_done_o   = sdone_q;
    assign bus_error_o      = err_q;

endmodule

// File: tb/tb_urv_lsu.sv
// Directed bench for urv_lsu; load completions are scored against an expected-data queue.
module tb_urv_lsu;
    import urv_defs::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        e_valid_i, e_load_i, e_store_i;
    logic [2:0]  e_fun_i;
    logic [31:0] e_addr_i, e_data_i;
    logic        busy_o, misalign_o;
    logic [31:0] dm_addr_o, dm_data_s_o;
    logic [3:0]  dm_data_select_o;
    logic        dm_load_o, dm_store_o;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i, dm_store_done_i;
    logic [31:0] w_load_data_o;
    logic        w_load_done_o, w_store_done_o, bus_error_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_bus_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    urv_lsu #(.g_timeout_cycles(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .e_valid_i        (e_valid_i),
        .e_load_i         (e_load_i),
        .e_store_i        (e_store_i),
        .e_fun_i          (e_fun_i),
        .e_addr_i         (e_addr_i),
        .e_data_i         (e_data_i),
        .busy_o           (busy_o),
        .misalign_o       (misalign_o),
        .dm_addr_o        (dm_addr_o),
        .dm_data_s_o      (dm_data_s_o),
        .dm_data_select_o (dm_data_select_o),
        .dm_load_o        (dm_load_o),
        .dm_store_o       (dm_store_o),
        .dm_data_l_i      (dm_data_l_i),
        .dm_load_done_i   (dm_load_done_i),
        .dm_store_done_i  (dm_store_done_i),
        .w_load_data_o    (w_load_data_o),
        .w_load_done_o    (w_load_done_o),
        .w_store_done_o   (w_store_done_o),
        .bus_error_o      (bus_error_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one request for exactly one clock edge.
    task automatic drive_req(input logic ld, input logic st, input logic [2:0] fun,
                             input logic [31:0] addr, input logic [31:0] data);
        e_valid_i = 1'b1;
        e_load_i  = ld;
        e_store_i = st;
        e_fun_i   = fun;
        e_addr_i  = addr;
        e_data_i  = data;
        step();
        e_valid_i = 1'b0;
        e_load_i  = 1'b0;
        e_store_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && bus_error_o) n_bus_err++;
        if (!rst_i && w_load_done_o) begin
            chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("sb_load_data", w_load_data_o, exp_q.pop_front());
        end
    end

    initial begin : watchdog
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : main
        rst_i = 1'b1;
        e_valid_i = 1'b0; e_load_i = 1'b0; e_store_i = 1'b0;
        e_fun_i = 3'b000; e_addr_i = '0; e_data_i = '0;
        dm_data_l_i = '0; dm_load_done_i = 1'b0; dm_store_done_i = 1'b0;
        step(); step();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_strobes", {30'd0, dm_load_o, dm_store_o}, 0);
        chk("rst_addr", dm_addr_o, 0);
        chk("rst_sdata", dm_data_s_o, 0);
        chk("rst_select", 32'(dm_data_select_o), 0);
        chk("rst_pulses", {28'd0, misalign_o, w_load_done_o, w_store_done_o, bus_error_o}, 0);
        chk("rst_ldata", w_load_data_o, 0);
        rst_i = 1'b0;
        step();

        // SW, done on the first strobe cycle
        drive_req(1'b0, 1'b1, LDST_L, 32'h0000_1000, 32'hDEAD_BEEF);
        dm_store_done_i = 1'b1;
        chk("sw_store", 32'(dm_store_o), 1);
        chk("sw_busy", 32'(busy_o), 1);
        chk("sw_addr", dm_addr_o, 32'h0000_1000);
        chk("sw_select", 32'(dm_data_select_o), 32'hF);
        chk("sw_sdata", dm_data_s_o, 32'hDEAD_BEEF);
        chk("sw_done_early", 32'(w_store_done_o), 0);
        step();
        dm_store_done_i = 1'b0;
        chk("sw_done", 32'(w_store_done_o), 1);
        chk("sw_strobe_drop", 32'(dm_store_o), 0);
        chk("sw_busy_drop", 32'(busy_o), 0);
        step();
        chk("sw_done_pulse", 32'(w_store_done_o), 0);

        // SB to the top lane; a wrong-type done is ignored
        drive_req(1'b0, 1'b1, LDST_B, 32'h0000_2003, 32'h0000_00A5);
        chk("sb_sdata", dm_data_s_o, 32'hA5A5_A5A5);
        chk("sb_select", 32'(dm_data_select_o), 32'h8);
        chk("sb_addr", dm_addr_o, 32'h0000_2000);
        dm_load_done_i = 1'b1;
        step();
        dm_load_done_i = 1'b0;
        chk("sb_wrong_done", {30'd0, w_load_done_o, w_store_done_o}, 0);
        chk("sb_still_store", 32'(dm_store_o), 1);
        dm_store_done_i = 1'b1;
        step();
        dm_store_done_i = 1'b0;
        chk("sb_done", 32'(w_store_done_o), 1);
        chk("sb_ldata_kept", w_load_data_o, 0);

        // Both load and store set: load wins; next request back-to-back in the done cycle
        drive_req(1'b1, 1'b1, LDST_L, 32'h0000_5000, 32'h0);
        chk("lw_both_strobes", {30'd0, dm_load_o, dm_store_o}, 32'h2);
        exp_q.push_back(32'h1234_5678);
        dm_data_l_i = 32'h1234_5678;
        dm_load_done_i = 1'b1;
        step();
        dm_load_done_i = 1'b0;
        chk("lw_done", 32'(w_load_done_o), 1);
        chk("lw_gap_strobe", 32'(dm_load_o), 0);

        // LH with 5 wait cycles: strobe high for 6 cycles
        drive_req(1'b1, 1'b0, LDST_H, 32'h0000_3002, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("lh_wait_strobe", 32'(dm_load_o), 1);
            step();
        end
        chk("lh_select", 32'(dm_data_select_o), 32'hC);
        chk("lh_addr", dm_addr_o, 32'h0000_3000);
        chk("lh_strobe6", 32'(dm_load_o), 1);
        exp_q.push_back(32'h8001_1234);
        dm_data_l_i = 32'h8001_1234;
        dm_load_done_i = 1'b1;
        step();
        dm_load_done_i = 1'b0;
        dm_data_l_i = 32'h0;
        chk("lh_done", 32'(w_load_done_o), 1);
        chk("lh_data", w_load_data_o, 32'h8001_1234);
        chk("lh_strobe_drop", 32'(dm_load_o), 0);

        // Misaligned LW presented in the done cycle
        drive_req(1'b1, 1'b0, LDST_L, 32'h0000_4001, 32'h0);
        chk("mis_pulse", 32'(misalign_o), 1);
        chk("mis_no_load", 32'(dm_load_o), 0);
        chk("mis_not_busy", 32'(busy_o), 0);
        chk("mis_no_done", 32'(w_load_done_o), 0);
        step();
        chk("mis_pulse_end", 32'(misalign_o), 0);
        chk("mis_idle_load", 32'(dm_load_o), 0);

        // Done while idle is ignored
        dm_load_done_i = 1'b1;
        dm_store_done_i = 1'b1;
        step();
        dm_load_done_i = 1'b0;
        dm_store_done_i = 1'b0;
        chk("idle_done_ignored", {30'd0, w_load_done_o, w_store_done_o}, 0);

`ifdef URV_LSU_TIMEOUT_EN
        drive_req(1'b1, 1'b0, LDST_L, 32'h0000_8000, 32'h0);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("tmo_wait_err", 32'(bus_error_o), 0);
            chk("tmo_wait_load", 32'(dm_load_o), 1);
            step();
        end
        chk("tmo_error", 32'(bus_error_o), 1);
        chk("tmo_done", 32'(w_load_done_o), 1);
        chk("tmo_data_zero", w_load_data_o, 0);
        chk("tmo_strobe_drop", 32'(dm_load_o), 0);
        chk("tmo_busy_drop", 32'(busy_o), 0);
        step();
        chk("tmo_error_pulse", 32'(bus_error_o), 0);
        // Done on the expiry cycle wins
        drive_req(1'b1, 1'b0, LDST_L, 32'h0000_8004, 32'h0);
        step(); step(); step();
        exp_q.push_back(32'h55AA_55AA);
        dm_data_l_i = 32'h55AA_55AA;
        dm_load_done_i = 1'b1;
        step();
        dm_load_done_i = 1'b0;
        chk("tmo_race_err", 32'(bus_error_o), 0);
        chk("tmo_race_done", 32'(w_load_done_o), 1);
        chk("tmo_error_count", 32'(n_bus_err), 1);
`else
        drive_req(1'b1, 1'b0, LDST_L, 32'h0000_8000, 32'h0);
        repeat (300) step();
        chk("wait_load", 32'(dm_load_o), 1);
        chk("wait_busy", 32'(busy_o), 1);
        exp_q.push_back(32'hCAFE_F00D);
        dm_data_l_i = 32'hCAFE_F00D;
        dm_load_done_i = 1'b1;
        step();
        dm_load_done_i = 1'b0;
        chk("wait_done", 32'(w_load_done_o), 1);
        chk("no_bus_error", 32'(n_bus_err), 0);
`endif

        // Reset during the 3rd wait cycle of an LB
        drive_req(1'b1, 1'b0, LDST_BU, 32'h0000_6001, 32'h0);
        chk("lb_select", 32'(dm_data_select_o), 32'h2);
        step(); step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rst_mid_load", 32'(dm_load_o), 0);
        chk("rst_mid_busy", 32'(busy_o), 0);
        chk("rst_mid_done", 32'(w_load_done_o), 0);
        chk("rst_mid_ldata", w_load_data_o, 0);

        // SH accepted normally after reset
        drive_req(1'b0, 1'b1, LDST_HU, 32'h0000_7002, 32'h0000_BEEF);
        chk("sh_sdata", dm_data_s_o, 32'hBEEF_BEEF);
        chk("sh_select", 32'(dm_data_select_o), 32'hC);
        chk("sh_addr", dm_addr_o, 32'h0000_7000);
        dm_store_done_i = 1'b1;
        step();
        dm_store_done_i = 1'b0;
        chk("sh_done", 32'(w_store_done_o), 1);
        step();

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
